// File: rtl/traffic_phase_sequencer.sv
// Traffic phase sequencer: steps main/side/walk lamp phases and restarts the interval timer on each phase entry.
// State, lamps, Value and start_timer are all registered; the timer's expiry is the only thing that advances a phase.
module traffic_phase_sequencer #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       expired,
  output logic [3:0] Value,
  output logic       start_timer,
  output logic [2:0] main_lamps,
  output logic [2:0] side_lamps,
  output logic       walk_lamp
);

  if (T_BASE < 1 || T_BASE > 15 || T_EXT < 1 || T_EXT > 15 || T_YEL < 1 || T_YEL > 15) begin : g_bad_param
    $error("traffic_phase_sequencer: intervals must lie in 1..15");
  end

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [3:0] V_BASE = 4'(T_BASE);
  localparam logic [3:0] V_EXT  = 4'(T_EXT);
  localparam logic [3:0] V_YEL  = 4'(T_YEL);

  typedef enum logic [2:0] {
    MAIN_G1, MAIN_G2, MAIN_Y, WALK, SIDE_G, SIDE_GX, SIDE_Y
  } state_t;

  state_t     state, next_state;
  logic [1:0] sensor_q;
  logic [2:0] walk_q;
  logic [2:0] exp_q;
  logic [2:0] blank_cnt;
  logic       restart_pend;
  logic       walk_pending;
  logic       sensor_s, walk_edge, exp_edge, advance;
  logic [3:0] nxt_value;
  logic [2:0] nxt_main, nxt_side;
  logic       nxt_walk;

  assign sensor_s  = sensor_q[1];
  assign walk_edge = walk_q[1] & ~walk_q[2];
  assign exp_edge  = exp_q[1] & ~exp_q[2];
  // Edges inside the blanking window are the previous interval's expiry still crossing the synchronizer.
  assign advance   = exp_edge && (blank_cnt == 3'd0);

  always_comb begin
    next_state = state;
    if (advance) begin
      case (state)
        MAIN_G1: next_state = MAIN_G2;
        MAIN_G2: next_state = MAIN_Y;
        MAIN_Y:  next_state = walk_pending ? WALK : SIDE_G;
        WALK:    next_state = SIDE_G;
        SIDE_G:  next_state = sensor_s ? SIDE_GX : SIDE_Y;
        SIDE_GX: next_state = SIDE_Y;
        SIDE_Y:  next_state = MAIN_G1;
        default: next_state = MAIN_G1;
      endcase
    end
  end

  always_comb begin
    nxt_value = V_BASE;
    nxt_main  = RED;
    nxt_side  = RED;
    nxt_walk  = 1'b0;
    case (next_state)
      MAIN_G1: nxt_main = GRN;
      MAIN_G2: begin
        nxt_main  = GRN;
        nxt_value = sensor_s ? V_EXT : V_BASE;
      end
      MAIN_Y: begin
        nxt_main  = YEL;
        nxt_value = V_YEL;
      end
      WALK: begin
        nxt_walk  = 1'b1;
        nxt_value = V_EXT;
      end
      SIDE_G:  nxt_side = GRN;
      SIDE_GX: begin
        nxt_side  = GRN;
        nxt_value = V_EXT;
      end
      SIDE_Y: begin
        nxt_side  = YEL;
        nxt_value = V_YEL;
      end
      default: nxt_main = GRN;
    endcase
  end

  always_ff @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      state        <= MAIN_G1;
      sensor_q     <= '0;
      walk_q       <= '0;
      exp_q        <= '0;
      blank_cnt    <= '0;
      restart_pend <= 1'b1;
      walk_pending <= 1'b0;
      Value        <= V_BASE;
      start_timer  <= 1'b0;
      main_lamps   <= GRN;
      side_lamps   <= RED;
      walk_lamp    <= 1'b0;
    end else begin
      sensor_q     <= {sensor_q[0], Sensor};
      walk_q       <= {walk_q[1:0], Walk_Request};
      exp_q        <= {exp_q[1:0], expired};
      state        <= next_state;
      main_lamps   <= nxt_main;
      side_lamps   <= nxt_side;
      walk_lamp    <= nxt_walk;
      restart_pend <= 1'b0;
      start_timer  <= advance | restart_pend;
      // Value only moves at a phase entry so the timer's autonomous reload never sees a change mid-interval.
      if (advance) Value <= nxt_value;
      if (advance || restart_pend) blank_cnt <= 3'd4;
      else if (blank_cnt != 3'd0) blank_cnt <= blank_cnt - 3'd1;
      walk_pending <= (walk_pending & ~(advance && next_state == WALK)) | walk_edge;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a behavioural interval timer (8 clk per second).
module tb_traffic_phase_sequencer;

  localparam int SEC = 8;
  localparam int BOUND = 200;

  logic       clk = 1'b0;
  logic       Reset_Sync = 1'b1;
  logic       Sensor = 1'b0;
  logic       Walk_Request = 1'b0;
  logic       expired;
  logic [3:0] Value;
  logic       start_timer;
  logic [2:0] main_lamps, side_lamps;
  logic       walk_lamp;

  logic timer_en = 1'b1;
  logic man_exp = 1'b0;
  logic tmr_exp;
  int   tcnt;
  int   checks = 0;
  int   errors = 0;

  assign expired = timer_en ? tmr_exp : man_exp;

  traffic_phase_sequencer dut (
    .clk(clk), .Reset_Sync(Reset_Sync), .Sensor(Sensor), .Walk_Request(Walk_Request),
    .expired(expired), .Value(Value), .start_timer(start_timer),
    .main_lamps(main_lamps), .side_lamps(side_lamps), .walk_lamp(walk_lamp)
  );

  always #5 clk = ~clk;

  // Timer: loads Value seconds on start, raises expired at the end and holds it until the next start.
  always @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      tcnt <= 0;
      tmr_exp <= 1'b0;
    end else if (start_timer) begin
      tcnt <= int'(Value) * SEC;
      tmr_exp <= 1'b0;
    end else if (tcnt == 1) begin
      tcnt <= 0;
      tmr_exp <= 1'b1;
    end else if (tcnt != 0) begin
      tcnt <= tcnt - 1;
    end
  end

  // Phase ids: 0 MAIN_G1, 1 MAIN_G2, 2 MAIN_Y, 3 WALK, 4 SIDE_G, 5 SIDE_GX, 6 SIDE_Y -> {Value, main, side, walk}
  function automatic logic [10:0] exp_attr(int p, bit sens);
    case (p)
      0: return {4'd6, 3'b001, 3'b100, 1'b0};
      1: return {(sens ? 4'd3 : 4'd6), 3'b001, 3'b100, 1'b0};
      2: return {4'd2, 3'b010, 3'b100, 1'b0};
      3: return {4'd3, 3'b100, 3'b100, 1'b1};
      4: return {4'd6, 3'b100, 3'b001, 1'b0};
      5: return {4'd3, 3'b100, 3'b001, 1'b0};
      default: return {4'd2, 3'b100, 3'b010, 1'b0};
    endcase
  endfunction

  task automatic wait_start(output logic [10:0] obs, output bit ok);
    ok = 1'b0;
    obs = 'x;
    for (int i = 0; i < BOUND && !ok; i++) begin
      @(negedge clk);
      if (start_timer === 1'b1) begin
        ok = 1'b1;
        obs = {Value, main_lamps, side_lamps, walk_lamp};
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 Reset_Sync = 1'b1;
    repeat (3) @(negedge clk);
    Reset_Sync = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) wait_start(obs, ok);
    @(posedge clk);
    #2 Reset_Sync = 1'b1;
    #1;
    checks++;
    if ({main_lamps, side_lamps, walk_lamp, start_timer, Value} !== {3'b001, 3'b100, 1'b0, 1'b0, 4'd6}) begin
      errors++;
      $display("FAIL reset_async: got main=%b side=%b walk=%b start=%b V=%0d, need 001 100 0 0 6",
               main_lamps, side_lamps, walk_lamp, start_timer, Value);
    end
    repeat (2) @(negedge clk);
    Reset_Sync = 1'b0;
    @(negedge clk);
    checks++;
    if (start_timer !== 1'b1 || Value !== 4'd6) begin
      errors++;
      $display("FAIL reset_restart: got start=%b V=%0d, need start=1 V=6", start_timer, Value);
    end
    @(negedge clk);
    checks++;
    if (start_timer !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart_width: got start=%b, need 0", start_timer);
    end
  endtask

  task automatic test_idle();
    int ph[6] = '{0, 1, 2, 4, 6, 0};
    logic [10:0] obs, want;
    bit ok;
    Sensor = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wait_start(obs, ok);
      want = exp_attr(ph[i], 1'b0);
      checks++;
      if (!ok || obs !== want) begin
        errors++;
        $display("FAIL idle[%0d]: got {V,main,side,walk}=%b ok=%0d, need %b", i, obs, ok, want);
      end
      @(negedge clk);
      checks++;
      if (start_timer !== 1'b0) begin
        errors++;
        $display("FAIL idle_pulse[%0d]: got start=%b, need 0", i, start_timer);
      end
    end
  endtask

  task automatic test_sensor();
    int ph[7] = '{0, 1, 2, 4, 5, 6, 0};
    logic [10:0] obs, want;
    bit ok;
    Sensor = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wait_start(obs, ok);
      want = exp_attr(ph[i], 1'b1);
      checks++;
      if (!ok || obs !== want) begin
        errors++;
        $display("FAIL sensor[%0d]: got {V,main,side,walk}=%b ok=%0d, need %b", i, obs, ok, want);
      end
    end
    Sensor = 1'b0;
  endtask

  task automatic test_walk();
    int ph[16] = '{0, 1, 2, 3, 4, 6, 0, 1, 2, 3, 4, 6, 0, 1, 2, 4};
    logic [10:0] obs, want;
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wait_start(obs, ok);
      want = exp_attr(ph[i], 1'b0);
      checks++;
      if (!ok || obs !== want) begin
        errors++;
        $display("FAIL walk[%0d]: got {V,main,side,walk}=%b ok=%0d, need %b", i, obs, ok, want);
      end
      if (i == 0 || i == 3) begin
        @(negedge clk);
        Walk_Request = 1'b1;
        @(negedge clk);
        Walk_Request = 1'b0;
      end
    end
  endtask

  task automatic test_stale_expiry();
    logic [10:0] obs, want;
    bit ok;
    int extra;
    timer_en = 1'b0;
    man_exp = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if (start_timer !== 1'b1) begin
      errors++;
      $display("FAIL stale_start: got start=%b, need 1", start_timer);
    end
    man_exp = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (start_timer === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || main_lamps !== 3'b001) begin
      errors++;
      $display("FAIL stale_discard: got %0d starts main=%b, need 0 starts main=001", extra, main_lamps);
    end
    for (int i = 0; i < 2; i++) begin
      man_exp = 1'b0;
      repeat (5) @(negedge clk);
      man_exp = 1'b1;
      wait_start(obs, ok);
      want = exp_attr(i + 1, 1'b0);
      checks++;
      if (!ok || obs !== want) begin
        errors++;
        $display("FAIL stale_genuine[%0d]: got {V,main,side,walk}=%b ok=%0d, need %b", i, obs, ok, want);
      end
    end
    man_exp = 1'b0;
    timer_en = 1'b1;
  endtask

  task automatic test_reset_mid_walk();
    int ph[5] = '{0, 1, 2, 4, 6};
    logic [10:0] obs, want;
    bit ok;
    do_reset();
    wait_start(obs, ok);
    @(negedge clk);
    Walk_Request = 1'b1;
    @(negedge clk);
    Walk_Request = 1'b0;
    for (int i = 0; i < 3; i++) wait_start(obs, ok);
    checks++;
    if (!ok || obs !== exp_attr(3, 1'b0)) begin
      errors++;
      $display("FAIL midwalk_enter: got {V,main,side,walk}=%b ok=%0d, need %b", obs, ok, exp_attr(3, 1'b0));
    end
    Walk_Request = 1'b1;
    @(negedge clk);
    Walk_Request = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 Reset_Sync = 1'b1;
    #1;
    checks++;
    if ({main_lamps, side_lamps, walk_lamp} !== {3'b001, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL midwalk_reset: got main=%b side=%b walk=%b, need 001 100 0", main_lamps, side_lamps, walk_lamp);
    end
    repeat (2) @(negedge clk);
    Reset_Sync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_start(obs, ok);
      want = exp_attr(ph[i], 1'b0);
      checks++;
      if (!ok || obs !== want) begin
        errors++;
        $display("FAIL midwalk_after[%0d]: got {V,main,side,walk}=%b ok=%0d, need %b", i, obs, ok, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_sensor();
    test_walk();
    test_stale_expiry();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
